// File: rtl/microbitos_pkg.sv
// Shared definitions for the MicroBitos multi-cycle core: opcodes, ALU/jump
// function codes, FSM states and instruction field positions.
package microbitos_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FN_W   = 2;
    localparam int unsigned RY_LSB = 0 + FN_W;

    typedef enum logic [2:0] {
        OP_HALT = 3'b000,
        OP_LOAD = 3'b001,
        OP_STI  = 3'b010,
        OP_STR  = 3'b011,
        OP_MOVE = 3'b100,
        OP_MATH = 3'b101,
        OP_JMP  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_AND = 2'b10,
        FN_XOR = 2'b11
    } math_fn_e;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'b00,
        JC_Z      = 2'b01,
        JC_C      = 2'b10,
        JC_NZ     = 2'b11
    } jmp_cond_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_IMM,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    // Layout is {op, rx, ry, fn}, fn in the least significant bits.
    function automatic int unsigned rx_lsb(int unsigned rsel_w);
        return FN_W + rsel_w;
    endfunction

    function automatic int unsigned op_lsb(int unsigned rsel_w);
        return FN_W + 2 * rsel_w;
    endfunction

    function automatic int unsigned instr_width(int unsigned rsel_w);
        return OP_W + 2 * rsel_w + FN_W;
    endfunction

    function automatic logic is_two_word(opcode_e op, logic fn0);
        return ((op == OP_LOAD) && !fn0) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/microbitos_alu.sv
// Combinational ALU for the MicroBitos core: ADD/SUB/AND/XOR with zero and
// carry/borrow flags.
module microbitos_alu
    import microbitos_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [1:0]        fn_i,
    output logic [DATA_W-1:0] result_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] wide;

    // Extra top bit carries the ADD carry-out or the SUB borrow.
    always_comb begin
        wide = '0;
        case (math_fn_e'(fn_i))
            FN_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
            FN_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
            FN_AND:  wide = {1'b0, a_i & b_i};
            default: wide = {1'b0, a_i ^ b_i};
        endcase
    end

    assign result_o = wide[DATA_W-1:0];
    assign c_o      = wide[DATA_W];
    assign z_o      = (result_o == '0);

endmodule

// File: rtl/microbitos_mc.sv
// MicroBitos multi-cycle core with req/ack instruction and data buses.
// Optional MICROBITOS_RETIRE_CNT_EN adds the o_retired instruction counter.
module microbitos_mc
    import microbitos_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       NREGS    = 4,
    parameter int unsigned       RSEL_W   = $clog2(NREGS),
    parameter int unsigned       INSTR_W  = instr_width(RSEL_W),
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] i_Instruccion,
    input  logic               i_iack,
    output logic               o_ireq,
    output logic [ADDR_W-1:0]  o_Address_Instruction_Bus,
    input  logic [DATA_W-1:0]  i_DataIn_Bus,
    input  logic               i_dack,
    output logic               o_dreq,
    output logic               W_R,
    output logic [ADDR_W-1:0]  o_Address_Data_Bus,
    output logic [DATA_W-1:0]  o_DataOut_Bus,
    output logic               o_halted
`ifdef MICROBITOS_RETIRE_CNT_EN
    ,
    output logic [15:0]        o_retired
`endif
);

    localparam int unsigned RX_LSB = rx_lsb(RSEL_W);
    localparam int unsigned OP_LSB = op_lsb(RSEL_W);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, addr_q, addr_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   imm_q, imm_d, wdata_q, wdata_d;
    logic                we_q, we_d, z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic                rf_we, ireq, dreq, jmp_take, is_mem_op;
    logic [DATA_W-1:0]   rf_wdata, rx_val, ry_val, alu_res, imm_w;
    logic [ADDR_W-1:0]   rx_addr, ry_addr, imm_addr;
    logic                alu_z, alu_c;
    opcode_e             op;
    logic [RSEL_W-1:0]   rx, ry;
    logic [1:0]          fn;

    assign op     = opcode_e'(ir_q[OP_LSB +: OP_W]);
    assign rx     = ir_q[RX_LSB +: RSEL_W];
    assign ry     = ir_q[RY_LSB +: RSEL_W];
    assign fn     = ir_q[1:0];
    assign rx_val = regs_q[rx];
    assign ry_val = regs_q[ry];

    if (DATA_W >= ADDR_W) begin : g_addr_trunc
        assign rx_addr  = rx_val[ADDR_W-1:0];
        assign ry_addr  = ry_val[ADDR_W-1:0];
        assign imm_addr = imm_q[ADDR_W-1:0];
    end else begin : g_addr_zext
        assign rx_addr  = {{(ADDR_W-DATA_W){1'b0}}, rx_val};
        assign ry_addr  = {{(ADDR_W-DATA_W){1'b0}}, ry_val};
        assign imm_addr = {{(ADDR_W-DATA_W){1'b0}}, imm_q};
    end

    if (INSTR_W >= DATA_W) begin : g_imm_trunc
        assign imm_w = i_Instruccion[DATA_W-1:0];
    end else begin : g_imm_zext
        assign imm_w = {{(DATA_W-INSTR_W){1'b0}}, i_Instruccion};
    end

    microbitos_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (rx_val),
        .b_i      (ry_val),
        .fn_i     (fn),
        .result_o (alu_res),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    assign is_mem_op = (op == OP_STI) || (op == OP_STR) || ((op == OP_LOAD) && fn[0]);

    always_comb begin
        case (jmp_cond_e'(fn))
            JC_ALWAYS: jmp_take = 1'b1;
            JC_Z:      jmp_take = z_q;
            JC_C:      jmp_take = c_q;
            default:   jmp_take = !z_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        z_d      = z_q;
        c_d      = c_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        ireq     = 1'b0;
        dreq     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ireq = 1'b1;
                if (i_iack) begin
                    ir_d    = i_Instruccion;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = is_two_word(opcode_e'(i_Instruccion[OP_LSB +: OP_W]), i_Instruccion[0])
                              ? S_IMM : S_EXEC;
                end
            end
            S_IMM: begin
                ireq = 1'b1;
                if (i_iack) begin
                    imm_d   = imm_w;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = is_mem_op ? S_MEM : S_FETCH;
                case (op)
                    OP_HALT: state_d = S_HALT;
                    OP_LOAD: begin
                        if (fn[0]) begin
                            addr_d = ry_addr;
                            we_d   = 1'b0;
                        end else begin
                            rf_we    = 1'b1;
                            rf_wdata = imm_q;
                        end
                    end
                    OP_STI: begin
                        addr_d  = imm_addr;
                        wdata_d = rx_val;
                        we_d    = 1'b1;
                    end
                    OP_STR: begin
                        addr_d  = rx_addr;
                        wdata_d = ry_val;
                        we_d    = 1'b1;
                    end
                    OP_MOVE: begin
                        rf_we    = 1'b1;
                        rf_wdata = ry_val;
                    end
                    OP_MATH: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_res;
                        z_d      = alu_z;
                        c_d      = alu_c;
                    end
                    OP_JMP: if (jmp_take) pc_d = rx_addr;
                    default: ;
                endcase
            end
            S_MEM: begin
                dreq = 1'b1;
                if (i_dack) begin
                    rf_we    = !we_q;
                    rf_wdata = i_DataIn_Bus;
                    state_d  = S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (rf_we) begin
            regs_q[rx] <= rf_wdata;
        end
    end

    // Requests are masked by reset so a pending transfer drops the instant reset asserts.
    assign o_ireq                    = ireq & reset;
    assign o_dreq                    = dreq & reset;
    assign W_R                       = we_q & (state_q == S_MEM) & reset;
    assign o_Address_Instruction_Bus = pc_q;
    assign o_Address_Data_Bus        = addr_q;
    assign o_DataOut_Bus             = wdata_q;
    assign o_halted                  = (state_q == S_HALT);

`ifdef MICROBITOS_RETIRE_CNT_EN
    logic        retire;
    logic [15:0] retired_q;

    assign retire = ((state_q == S_EXEC) && !is_mem_op) || ((state_q == S_MEM) && i_dack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retired_q <= '0;
        else if (retire) retired_q <= retired_q + 16'd1;
    end

    assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_microbitos_mc.sv
// Directed self-checking bench for microbitos_mc: ROM/RAM responders with
// programmable wait states, fetch trace and data-access log checked against
// hand-computed programs.
module tb_microbitos_mc;

    localparam logic [2:0] HALT = 3'd0, LD = 3'd1, STI = 3'd2, STR = 3'd3,
                           MOV = 3'd4, MATH = 3'd5, JMP = 3'd6;

    logic       clk, reset;
    logic [8:0] i_Instruccion;
    logic       i_iack, o_ireq, i_dack, o_dreq, W_R, o_halted;
    logic [7:0] o_Address_Instruction_Bus, i_DataIn_Bus, o_Address_Data_Bus, o_DataOut_Bus;
`ifdef MICROBITOS_RETIRE_CNT_EN
    logic [15:0] o_retired;
`endif

    microbitos_mc dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_Instruccion             (i_Instruccion),
        .i_iack                    (i_iack),
        .o_ireq                    (o_ireq),
        .o_Address_Instruction_Bus (o_Address_Instruction_Bus),
        .i_DataIn_Bus              (i_DataIn_Bus),
        .i_dack                    (i_dack),
        .o_dreq                    (o_dreq),
        .W_R                       (W_R),
        .o_Address_Data_Bus        (o_Address_Data_Bus),
        .o_DataOut_Bus             (o_DataOut_Bus),
        .o_halted                  (o_halted)
`ifdef MICROBITOS_RETIRE_CNT_EN
        ,
        .o_retired                 (o_retired)
`endif
    );

    typedef struct { int cyc; int addr; } fetch_t;
    typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; int cycles; bit stable; } acc_t;

    logic [8:0] rom [256];
    fetch_t     fq[$];
    acc_t       acc_log[$];
    acc_t       cur;
    int         dwait_tab [8] = '{3, 0, 0, 0, 1000, 2, 0, 0};
    int         acc_idx = 0;
    int         dcnt = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] enc(logic [2:0] op, logic [1:0] rx, logic [1:0] ry, logic [1:0] fn);
        return {op, rx, ry, fn};
    endfunction

    function automatic logic [8:0] imm(logic [7:0] v);
        return {1'b0, v};
    endfunction

    // ROM and RAM responders: acks and read data change only on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            i_iack = 1'b0;
            i_dack = 1'b0;
            i_DataIn_Bus = '0;
            if (dcnt != 0) begin
                acc_idx++;
                dcnt = 0;
            end
        end else begin
            i_Instruccion = rom[o_Address_Instruction_Bus];
            i_iack = o_ireq;
            if (o_ireq) fq.push_back('{cyc, int'(o_Address_Instruction_Bus)});
            i_dack = 1'b0;
            i_DataIn_Bus = '0;
            if (o_dreq) begin
                if (dcnt == 0) begin
                    cur.wr = W_R;
                    cur.addr = o_Address_Data_Bus;
                    cur.data = o_DataOut_Bus;
                    cur.stable = 1'b1;
                end else if (W_R !== cur.wr || o_Address_Data_Bus !== cur.addr ||
                             (cur.wr && o_DataOut_Bus !== cur.data)) begin
                    cur.stable = 1'b0;
                end
                dcnt++;
                if (dcnt > dwait_tab[acc_idx]) begin
                    i_dack = 1'b1;
                    if (!cur.wr) begin
                        i_DataIn_Bus = 8'h5A;
                        cur.data = 8'h5A;
                    end
                    cur.cycles = dcnt;
                    acc_log.push_back(cur);
                    acc_idx++;
                    dcnt = 0;
                end
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    endtask

    task automatic release_reset();
        fq.delete();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 400 && !o_halted; i++) @(negedge clk);
        #1 check(tag, o_halted, 1'b1);
    endtask

    task automatic check_quiet(input string tag, input int nfetch);
        int busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 if (o_ireq || o_dreq) busy++;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, o_halted, 1'b1);
        check({tag, "_nfetch"}, fq.size(), nfetch);
    endtask

    function automatic int fcyc(int idx);
        return (idx < fq.size()) ? fq[idx].cyc : -1000;
    endfunction

    int exp_f1 [28] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                        'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29, 'h2A, 'hDF};
    int exp_f3 [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 'hFF, 0, 'h10, 'h11, 'h12};
    // {wr, addr, data}
    logic [16:0] exp_acc [6] = '{{1'b1, 8'h09, 8'h05}, {1'b1, 8'h50, 8'h00}, {1'b1, 8'h20, 8'h21},
                                 {1'b1, 8'h20, 8'hDF}, {1'b0, 8'h80, 8'h5A}, {1'b1, 8'h42, 8'h5A}};

    initial begin
        reset = 1'b0;
        i_Instruccion = '0;
        i_iack = 1'b0;
        i_dack = 1'b0;
        i_DataIn_Bus = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_ireq", o_ireq, 1'b0);
        check("rst_dreq", o_dreq, 1'b0);
        check("rst_wr", W_R, 1'b0);
        check("rst_halted", o_halted, 1'b0);
        check("rst_iaddr", o_Address_Instruction_Bus, 8'h00);
        check("rst_daddr", o_Address_Data_Bus, 8'h00);
        check("rst_dout", o_DataOut_Bus, 8'h00);
`ifdef MICROBITOS_RETIRE_CNT_EN
        check("rst_retired", o_retired, 16'd0);
`endif

        // Program 1: arithmetic, flags, conditional jumps, stalled store, HALT.
        clear_rom();
        rom[0]    = enc(LD, 1, 0, 0);   rom[1]    = imm(8'h04);
        rom[2]    = enc(LD, 2, 0, 0);   rom[3]    = imm(8'h05);
        rom[4]    = enc(MATH, 1, 2, 0);
        rom[5]    = enc(LD, 3, 0, 0);   rom[6]    = imm(8'h20);
        rom[7]    = enc(JMP, 3, 0, 1);
        rom[8]    = enc(JMP, 3, 0, 2);
        rom[9]    = enc(STR, 1, 2, 0);
        rom[10]   = enc(LD, 0, 0, 0);   rom[11]   = imm(8'hFF);
        rom[12]   = enc(LD, 2, 0, 0);   rom[13]   = imm(8'h01);
        rom[14]   = enc(MATH, 0, 2, 0);
        rom[15]   = enc(JMP, 3, 0, 1);
        rom[8'h20] = enc(MATH, 1, 1, 1);
        rom[8'h21] = enc(JMP, 3, 0, 3);
        rom[8'h22] = enc(JMP, 3, 0, 2);
        rom[8'h23] = enc(STI, 1, 0, 0); rom[8'h24] = imm(8'h50);
        rom[8'h25] = enc(MATH, 2, 3, 3);
        rom[8'h26] = enc(MOV, 0, 2, 0);
        rom[8'h27] = enc(STR, 3, 0, 0);
        rom[8'h28] = enc(MATH, 1, 2, 1);
        rom[8'h29] = enc(STR, 3, 1, 0);
        rom[8'h2A] = enc(JMP, 1, 0, 2);
        rom[8'hDF] = enc(HALT, 0, 0, 0);
        release_reset();
        #1 check("first_ireq", o_ireq, 1'b1);
        wait_halt("p1_halt");
        check_quiet("p1", 28);
        for (int i = 0; i < 28; i++)
            check($sformatf("p1_fetch[%0d]", i), (i < fq.size()) ? fq[i].addr : -1, exp_f1[i]);
        check("p1_lat_ldimm", fcyc(2) - fcyc(0), 3);
        check("p1_lat_math", fcyc(5) - fcyc(4), 2);
        check("p1_lat_str_wait3", fcyc(10) - fcyc(9), 6);
        check("p1_lat_sti", fcyc(21) - fcyc(19), 4);
        check("p1_nacc", acc_log.size(), 4);
        check("p1_str_cycles", (acc_log.size() > 0) ? acc_log[0].cycles : -1, 4);
        check("p1_str_stable", (acc_log.size() > 0) ? acc_log[0].stable : 1'b0, 1'b1);
`ifdef MICROBITOS_RETIRE_CNT_EN
        check("p1_retired", o_retired, 16'd22);
`endif

        // Program 2: reset asserted while a store is waiting for its ack.
        reset = 1'b0;
        clear_rom();
        rom[0] = enc(LD, 1, 0, 0); rom[1] = imm(8'h33);
        rom[2] = enc(STR, 1, 1, 0);
        release_reset();
        for (int i = 0; i < 50 && !o_dreq; i++) @(negedge clk);
        #1;
        check("p2_dreq", o_dreq, 1'b1);
        check("p2_wr", W_R, 1'b1);
        check("p2_daddr", o_Address_Data_Bus, 8'h33);
        check("p2_dout", o_DataOut_Bus, 8'h33);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("p2_rst_dreq", o_dreq, 1'b0);
        check("p2_rst_wr", W_R, 1'b0);
        check("p2_rst_ireq", o_ireq, 1'b0);
        check("p2_rst_pc", o_Address_Instruction_Bus, 8'h00);
        repeat (3) @(negedge clk);
        check("p2_nacc", acc_log.size(), 4);

        // Program 3: indirect load with two wait states across the PC wrap.
        clear_rom();
        rom[0]     = enc(JMP, 3, 0, 2);
        rom[1]     = enc(LD, 3, 0, 0);  rom[2]     = imm(8'h10);
        rom[3]     = enc(LD, 1, 0, 0);  rom[4]     = imm(8'h80);
        rom[5]     = enc(LD, 2, 0, 0);  rom[6]     = imm(8'hFF);
        rom[7]     = enc(LD, 0, 0, 0);  rom[8]     = imm(8'h01);
        rom[9]     = enc(MATH, 2, 0, 0);
        rom[10]    = enc(LD, 2, 0, 0);  rom[11]    = imm(8'hFF);
        rom[12]    = enc(JMP, 2, 0, 0);
        rom[8'hFF] = enc(LD, 0, 1, 1);
        rom[8'h10] = enc(STI, 0, 0, 0); rom[8'h11] = imm(8'h42);
        rom[8'h12] = enc(HALT, 0, 0, 0);
        release_reset();
        wait_halt("p3_halt");
        check_quiet("p3", 18);
        for (int i = 0; i < 18; i++)
            check($sformatf("p3_fetch[%0d]", i), (i < fq.size()) ? fq[i].addr : -1, exp_f3[i]);
        check("p3_lat_ldind_wait2", fcyc(14) - fcyc(13), 5);
        check("p3_nacc", acc_log.size(), 6);
        check("p3_ld_cycles", (acc_log.size() > 4) ? acc_log[4].cycles : -1, 3);
`ifdef MICROBITOS_RETIRE_CNT_EN
        check("p3_retired", o_retired, 16'd12);
`endif

        for (int i = 0; i < 6; i++) begin
            if (i < acc_log.size())
                check($sformatf("acc[%0d]", i), {acc_log[i].wr, acc_log[i].addr, acc_log[i].data}, exp_acc[i]);
            else
                check($sformatf("acc[%0d]_missing", i), 17'h1FFFF, exp_acc[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
